// File: rtl/ac_pkg.sv
// ac_pkg: shared record encodings, parser state set and record type for the AC table loader.
package ac_pkg;
  localparam logic [2:0] SEL_CUR = 3'd0;
  localparam logic [2:0] SEL_CHARA = 3'd1;
  localparam logic [2:0] SEL_NEXT = 3'd2;
  localparam logic [2:0] SEL_FAIL = 3'd3;
  localparam logic [2:0] SEL_END = 3'd7;
  localparam int REC_BYTES = 3;
  localparam int TABLE_DEPTH = 32;
  typedef enum logic [1:0] {ST_HDR, ST_DAT, ST_CHK, ST_COMMIT} rec_state_e;
  typedef struct packed {
    logic       valid;
    logic       good;
    logic [2:0] sel;
    logic [4:0] addr;
    logic [7:0] data;
  } rec_t;
  function automatic logic is_data_sel(input logic [2:0] sel);
    return !sel[2];
  endfunction
  // The chara table only stores a nibble; the upper bits are forced to zero.
  function automatic logic [7:0] entry_data(input logic [2:0] sel, input logic [7:0] data);
    return sel == SEL_CHARA ? {4'h0, data[3:0]} : data;
  endfunction
endpackage

// File: rtl/ac_table_writer_if.sv
// ac_table_writer_if: config byte stream in, table RAM write port and load status out.
interface ac_table_writer_if #(parameter int ADDR_W = 5, parameter int ERR_CNT_W = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_data;
  logic                 wr_en;
  logic [1:0]           wr_sel;
  logic [ADDR_W-1:0]    wr_addr;
  logic [7:0]           wr_data;
  logic                 table_ready;
  logic [5:0]           rec_count;
  logic                 err_flag;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_sel, wr_addr, wr_data, table_ready, rec_count, err_flag, err_count
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_sel, wr_addr, wr_data, table_ready, rec_count, err_flag, err_count
  );
endinterface

// File: rtl/ac_rec_parser.sv
// ac_rec_parser: collects 3-byte records and presents each one for a single COMMIT cycle.
module ac_rec_parser
  import ac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output rec_t       rec
);
  localparam logic [1:0] HDR = ST_HDR;
  localparam logic [1:0] DAT = ST_DAT;
  localparam logic [1:0] CHK = ST_CHK;
  logic [1:0] state;
  logic [7:0] hdr, dat;
  logic       fire;
  assign fire = in_valid && in_ready;
  // in_ready is its own flop so it never depends combinationally on in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HDR;
      in_ready <= 1'b1;
      hdr <= '0;
      dat <= '0;
      rec <= '0;
    end else begin
      rec.valid <= 1'b0;
      case (state)
        HDR: if (fire) begin
          hdr <= in_data;
          state <= DAT;
        end
        DAT: if (fire) begin
          dat <= in_data;
          state <= CHK;
        end
        CHK: if (fire) begin
          state <= ST_COMMIT;
          in_ready <= 1'b0;
          rec <= '{valid: 1'b1, good: in_data == (hdr ^ dat), sel: hdr[7:5], addr: hdr[4:0], data: dat};
        end
        default: begin
          state <= HDR;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: rtl/ac_table_writer.sv
// ac_table_writer: turns parsed records into table RAM writes and tracks load/error status.
module ac_table_writer
  import ac_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  ac_table_writer_if.slave bus
);
  rec_t                 rec;
  logic                 data_ok, end_ok;
  logic [1:0]           last_sel;
  logic [ADDR_W-1:0]    last_addr;
  logic [7:0]           last_data;
  logic                 table_ready, err_flag;
  logic [5:0]           rec_count;
  logic [ERR_CNT_W-1:0] err_count;
  ac_rec_parser u_parser (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .in_ready (bus.in_ready),
    .rec      (rec)
  );
  always_comb begin
    data_ok = rec.valid && rec.good && is_data_sel(rec.sel);
    end_ok = rec.valid && rec.good && rec.sel == SEL_END;
  end
  // The write port shows the committing record, otherwise the last written entry.
  assign bus.wr_en = data_ok;
  assign bus.wr_sel = data_ok ? rec.sel[1:0] : last_sel;
  assign bus.wr_addr = data_ok ? ADDR_W'(rec.addr) : last_addr;
  assign bus.wr_data = data_ok ? entry_data(rec.sel, rec.data) : last_data;
  assign bus.table_ready = table_ready;
  assign bus.rec_count = rec_count;
  assign bus.err_flag = err_flag;
  assign bus.err_count = err_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sel <= '0;
      last_addr <= '0;
      last_data <= '0;
      table_ready <= 1'b0;
      rec_count <= '0;
      err_flag <= 1'b0;
      err_count <= '0;
    end else if (data_ok) begin
      last_sel <= rec.sel[1:0];
      last_addr <= ADDR_W'(rec.addr);
      last_data <= entry_data(rec.sel, rec.data);
      table_ready <= 1'b0;
      // A data record after a completed set starts a fresh load.
      if (table_ready) err_flag <= 1'b0;
      rec_count <= table_ready ? 6'd1 : (&rec_count ? rec_count : rec_count + 6'd1);
    end else if (end_ok) begin
      table_ready <= 1'b1;
    end else if (rec.valid) begin
      err_flag <= 1'b1;
      err_count <= &err_count ? err_count : err_count + 1'b1;
    end
  end
endmodule
